// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bundle and register-file write port shared by the arbiter and its requesters.
// slave = arbiter side, master = requester / register-file side.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          stall;
    logic                          ctrl_writeEnable;
    logic [ADDR_WIDTH-1:0]         ctrl_writeReg;
    logic [DATA_WIDTH-1:0]         data_writeReg;
    logic [2:0]                    grant_id;
    logic                          conflict;

    modport slave (
        input  req_valid, req_addr, req_data, stall,
        output req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, grant_id, conflict
    );

    modport master (
        output req_valid, req_addr, req_data, stall,
        input  req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, grant_id, conflict
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port; 1-cycle latency from handshake to write.
// Backpressure: ready is a combinational one-hot grant, withheld entirely while stall or reset is active.
module regfile_write_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                   i_clock,
    input  logic                   i_clr,
    regfile_write_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]      r_ptr;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_reg;
    logic [DATA_WIDTH-1:0] r_data;
    logic [2:0]            r_gid;
    logic                  r_conf;

    logic [PTR_W-1:0]      w_sel;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic                  w_grant;
    logic [NUM_REQ-1:0]    w_ready;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_conflict;

    // Scan from the farthest offset down so the requester closest to r_ptr wins.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        idx     = 0;
        cand    = '0;
        w_sel   = '0;
        w_grant = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = idx[PTR_W-1:0];
            if (bus.req_valid[cand]) begin
                w_sel   = cand;
                w_grant = 1'b1;
            end
        end
        if (bus.stall || !i_clr) begin
            w_grant = 1'b0;
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_grant) begin
            w_ready[w_sel] = 1'b1;
        end
    end

    assign w_ptr_nxt  = (w_sel == PTR_W'(NUM_REQ - 1)) ? '0 : w_sel + PTR_W'(1);
    assign w_addr     = bus.req_addr[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data     = bus.req_data[w_sel*DATA_WIDTH +: DATA_WIDTH];
    assign w_conflict = ($countones(bus.req_valid) > 1);

    always_ff @(posedge i_clock or negedge i_clr) begin
        if (!i_clr) begin
            r_ptr  <= '0;
            r_we   <= 1'b0;
            r_reg  <= '0;
            r_data <= '0;
            r_gid  <= '0;
            r_conf <= 1'b0;
        end else if (w_grant) begin
            // Register 0 is accepted and consumes its turn but never reaches the write port.
            r_we   <= (w_addr != '0);
            r_reg  <= w_addr;
            r_data <= w_data;
            r_gid  <= 3'(w_sel);
            r_ptr  <= w_ptr_nxt;
            r_conf <= w_conflict;
        end else begin
            r_we   <= 1'b0;
            r_conf <= 1'b0;
        end
    end

    assign bus.req_ready        = w_ready;
    assign bus.ctrl_writeEnable = r_we;
    assign bus.ctrl_writeReg    = r_reg;
    assign bus.data_writeReg    = r_data;
    assign bus.grant_id         = r_gid;
    assign bus.conflict         = r_conf;
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg) among NUM_REQ writeback sources, e.g. ALU, multdiv, load unit.
- Fair round-robin arbitration with a valid/ready handshake per requester.
- The granted write is registered into an output stage that drives the register-file write port for exactly one cycle.
- Sits between the writeback sources and the 32 x 32-bit register file.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
DATA_WIDTH, 32, write data width
ADDR_WIDTH, 5, register address width

Ports:
clock  input  1  system clock; all state updates on rising edge
clr  input  1  reset, asynchronous, active-low; clears all state while low
req_valid  input  NUM_REQ  per-requester write request
req_addr  input  NUM_REQ*ADDR_WIDTH  packed destination register, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data  input  NUM_REQ*DATA_WIDTH  packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  one-hot grant; the handshake completes on the edge where valid&ready
stall  input  1  pipeline freeze; blocks all grants
ctrl_writeEnable  output  1  register-file write enable
ctrl_writeReg  output  ADDR_WIDTH  register-file write address
data_writeReg  output  DATA_WIDTH  register-file write data
grant_id  output  3  index of the requester whose write is in the output stage
conflict  output  1  registered pulse: more than one valid requester in the previous arbitrated cycle

Behaviour:
- State:
  - rr_ptr (0..NUM_REQ-1): highest-priority requester index.
  - Output stage: ctrl_writeEnable, ctrl_writeReg, data_writeReg, grant_id, conflict.
- Reset (clr low, asynchronous): rr_ptr=0; all outputs 0. req_ready is forced 0 while clr is low.
- Reset released mid-request: arbitration restarts with rr_ptr=0. Requests in flight before reset are not remembered; requesters keep valid asserted and are re-arbitrated.
- Grant, combinational:
  - If stall=0, sel = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready is one-hot at sel, or all 0 if no valid requester or stall=1.
  - req_ready depends on req_valid; requesters must not make valid depend on ready.
- On a rising edge with a grant:
  - ctrl_writeEnable <= (req_addr[sel] != 0).
  - ctrl_writeReg <= req_addr[sel]; data_writeReg <= req_data[sel]; grant_id <= sel.
  - rr_ptr <= (sel+1) mod NUM_REQ.
  - conflict <= (popcount(req_valid) > 1).
- On a rising edge with no grant (idle or stall):
  - ctrl_writeEnable <= 0; conflict <= 0.
  - ctrl_writeReg, data_writeReg, grant_id and rr_ptr hold.
- Latency: exactly 1 cycle from handshake edge to write-port assertion. ctrl_writeEnable is high for exactly 1 cycle per accepted non-zero-address write.
- Throughput: one write per cycle; back-to-back grants are allowed.
- Register 0:
  - A write to address 0 is accepted normally (ready=1, rr_ptr advances, grant_id updates).
  - ctrl_writeEnable stays 0, so $0 stays zero.
- Fairness: with stall=0 and requester i continuously valid, i is granted within NUM_REQ cycles.
- rr_ptr wrap: after granting NUM_REQ-1, rr_ptr becomes 0.
- Simultaneous same address: arbitration order alone determines the write order; the later grant is the final register value. No merging.
- Stall asserted while a write sits in the output stage: that write still completes on the next cycle; the cycle after a stalled edge shows writeEnable=0.
- Requester data/address must be stable while valid=1 and ready=0.

Test Plan:
1. Reset then single write: clr low 2 cycles; check all outputs 0. Release; req_valid=3'b010, addr=7, data=0xDEADBEEF → ready=3'b010 same cycle. Next cycle: writeEnable=1, writeReg=7, data=0xDEADBEEF, grant_id=1. Following cycle: writeEnable=0. Afterwards rr_ptr=2.
2. Round-robin: all three valid continuously, addrs 1/2/3 → grants 0,1,2,0,1,2 on consecutive cycles. writeReg sequence 1,2,3,1,2,3; conflict=1 each cycle; writeEnable held high.
3. Register 0: requester 0 valid, addr=0, data=0xFFFFFFFF → ready=3'b001. Next cycle: writeEnable=0, grant_id=0. rr_ptr advances to 1.
4. Stall: all valid, stall=1 for 3 cycles → ready=0 and writeEnable=0 throughout; rr_ptr unchanged. On stall release the grant goes to the requester at the saved rr_ptr.
5. Async reset mid-traffic: during scenario 2 drive clr low between clock edges → outputs go to 0 immediately without a clock edge; ready=0. After release, first grant goes to requester 0.
6. Fairness bound with NUM_REQ=3: requester 2 valid alone only in cycles where 0 and 1 are also valid continuously → requester 2 granted within 3 cycles of asserting valid, with its data unchanged at the write port.
